pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_ret_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 82 ++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: address width, default return-stack depth, op encodings.
package pc_sequencer_pkg;

  localparam int ADDR_W      = 12;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JSB    = 3'd3,
    OP_RET    = 3'd4
  } op_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Circular return-address stack; push overwrites the oldest entry when full, pop on empty is ignored.
// Updates at the clock edge; top_o is combinational from the stored entries.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           push_dat_i,
  output logic [W-1:0]           top_o,
  output logic [$clog2(DEPTH):0] depth_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   depth_q, depth_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  // ptr_q addresses the next free slot; when full it also addresses the oldest entry
  assign top_o   = mem_q[ptr_q - PW'(1)];
  assign depth_o = depth_q;
  assign full_o  = (depth_q == FULL_CNT);
  assign empty_o = (depth_q == '0);

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    mem_d   = mem_q;
    if (push_i) begin
      mem_d[ptr_q] = push_dat_i;
      ptr_d        = ptr_q + PW'(1);
      if (!full_o) depth_d = depth_q + (PW+1)'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d   = ptr_q - PW'(1);
      depth_d = depth_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection (INC/BRANCH/JUMP/JSB/RET) with a return stack and sticky overflow/underflow flags.
// next_pc_o is zero-latency combinational; stack and flags update at the edge ending the step.
module pc_sequencer #(
  parameter int DEPTH  = pc_sequencer_pkg::STACK_DEPTH,
  parameter int ADDR_W = pc_sequencer_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   step_i,
  input  logic [2:0]             op_i,
  input  logic [ADDR_W-1:0]      pc_i,
  input  logic                   cond_i,
  input  logic [7:0]             disp_i,
  input  logic [ADDR_W-1:0]      target_i,
  output logic [ADDR_W-1:0]      next_pc_o,
  output logic                   pc_we_o,
  output logic [$clog2(DEPTH):0] depth_o,
  output logic                   ovf_o,
  output logic                   unf_o
);

  import pc_sequencer_pkg::*;

  logic [ADDR_W-1:0] inc_pc, br_pc, top;
  logic              full, empty, push, pop;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  assign pc_we_o = step_i & cen & ~rst;
  assign inc_pc  = pc_i + ADDR_W'(1);
  assign br_pc   = inc_pc + {{(ADDR_W-8){disp_i[7]}}, disp_i};

  always_comb begin
    next_pc_o = inc_pc;
    push      = 1'b0;
    pop       = 1'b0;
    if (pc_we_o) begin
      case (op_i)
        OP_BRANCH: if (cond_i) next_pc_o = br_pc;
        OP_JUMP:   next_pc_o = target_i;
        OP_JSB: begin
          next_pc_o = target_i;
          push      = 1'b1;
        end
        OP_RET: begin
          next_pc_o = empty ? '0 : top;
          pop       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ovf_d = ovf_q | (push & full);
  assign unf_d = unf_q | (pop & empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (cen) begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;

  ret_stack #(.DEPTH(DEPTH), .W(ADDR_W)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (pop),
    .push_dat_i (inc_pc),
    .top_o      (top),
    .depth_o    (depth_o),
    .full_o     (full),
    .empty_o    (empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: combinational next-PC vector table plus stack/flag sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, cen, step_i, cond_i;
  logic [2:0]  op_i;
  logic [11:0] pc_i, target_i, next_pc_o;
  logic [7:0]  disp_i;
  logic        pc_we_o, ovf_o, unf_o;
  logic [3:0]  depth_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.DEPTH(8), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .cen(cen), .step_i(step_i), .op_i(op_i),
    .pc_i(pc_i), .cond_i(cond_i), .disp_i(disp_i), .target_i(target_i),
    .next_pc_o(next_pc_o), .pc_we_o(pc_we_o), .depth_o(depth_o),
    .ovf_o(ovf_o), .unf_o(unf_o)
  );

  typedef struct {
    string       name;
    logic        cen;
    logic        step;
    logic [2:0]  op;
    logic [11:0] pc;
    logic        cond;
    logic [7:0]  disp;
    logic [11:0] target;
    logic [11:0] exp_next;
    logic        exp_we;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
  task automatic drive(input logic r, input logic c, input logic s, input logic [2:0] op,
                       input logic [11:0] pc, input logic cd, input logic [7:0] dp,
                       input logic [11:0] tg);
    @(negedge clk);
    rst = r; cen = c; step_i = s; op_i = op; pc_i = pc;
    cond_i = cd; disp_i = dp; target_i = tg;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 8'h00, 12'h000);
  endtask

  task automatic jsb(input logic [11:0] pc, input logic [11:0] tg);
    drive(1'b0, 1'b1, 1'b1, 3'd3, pc, 1'b0, 8'h00, tg);
  endtask

  task automatic ret(input logic c);
    drive(1'b0, c, 1'b1, 3'd4, 12'h030, 1'b0, 8'h00, 12'h000);
  endtask

  initial begin
    vecs[0]  = '{"inc_005",        1, 1, 3'd0, 12'h005, 0, 8'h00, 12'h000, 12'h006, 1};
    vecs[1]  = '{"inc_wrap",       1, 1, 3'd0, 12'hFFF, 0, 8'h00, 12'h000, 12'h000, 1};
    vecs[2]  = '{"br_taken_back",  1, 1, 3'd1, 12'h010, 1, 8'hFE, 12'h000, 12'h00F, 1};
    vecs[3]  = '{"br_not_taken",   1, 1, 3'd1, 12'h010, 0, 8'hFE, 12'h000, 12'h011, 1};
    vecs[4]  = '{"br_wrap",        1, 1, 3'd1, 12'hFFE, 1, 8'h05, 12'h000, 12'h004, 1};
    vecs[5]  = '{"br_max_fwd",     1, 1, 3'd1, 12'h000, 1, 8'h7F, 12'h000, 12'h080, 1};
    vecs[6]  = '{"br_max_back",    1, 1, 3'd1, 12'h100, 1, 8'h80, 12'h000, 12'h081, 1};
    vecs[7]  = '{"jump",           1, 1, 3'd2, 12'h123, 0, 8'h00, 12'h3A5, 12'h3A5, 1};
    vecs[8]  = '{"op5_as_inc",     1, 1, 3'd5, 12'h020, 1, 8'h10, 12'h777, 12'h021, 1};
    vecs[9]  = '{"op7_as_inc",     1, 1, 3'd7, 12'h0FF, 1, 8'h10, 12'h777, 12'h100, 1};
    vecs[10] = '{"jump_no_step",   1, 0, 3'd2, 12'h050, 0, 8'h00, 12'h3A5, 12'h051, 0};
    vecs[11] = '{"br_cen_low",     0, 1, 3'd1, 12'h010, 1, 8'hFE, 12'h000, 12'h011, 0};

    // reset, with a step request held to confirm pc_we_o is suppressed
    drive(1'b1, 1'b1, 1'b1, 3'd0, 12'h005, 1'b0, 8'h00, 12'h000);
    chk("we_in_reset", pc_we_o, 0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 8'h00, 12'h000);
    idle();
    chk("rst_depth", depth_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_unf", unf_o, 0);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].cen, vecs[i].step, vecs[i].op, vecs[i].pc,
            vecs[i].cond, vecs[i].disp, vecs[i].target);
      chk({vecs[i].name, "_next"}, next_pc_o, vecs[i].exp_next);
      chk({vecs[i].name, "_we"}, pc_we_o, vecs[i].exp_we);
    end

    // a RET with no step must not pop or flag underflow
    drive(1'b0, 1'b1, 1'b0, 3'd4, 12'h040, 1'b0, 8'h00, 12'h000);
    chk("ret_nostep_next", next_pc_o, 12'h041);
    idle();
    chk("ret_nostep_unf", unf_o, 0);
    chk("ret_nostep_depth", depth_o, 0);

    // simple call/return
    jsb(12'h100, 12'h200);
    chk("jsb_next", next_pc_o, 12'h200);
    chk("jsb_we", pc_we_o, 1);
    idle();
    chk("jsb_depth", depth_o, 1);
    ret(1'b1);
    chk("ret_next", next_pc_o, 12'h101);
    idle();
    chk("ret_depth", depth_o, 0);
    chk("ret_ovf", ovf_o, 0);
    chk("ret_unf", unf_o, 0);

    // nine calls overflow the 8-entry stack, nine returns underflow it
    for (int k = 1; k <= 9; k++) begin
      jsb(12'(k), 12'h400 + 12'(k));
      if (k == 8) begin
        idle();
        chk("full_depth", depth_o, 8);
        chk("full_no_ovf", ovf_o, 0);
      end
    end
    idle();
    chk("ovf_set", ovf_o, 1);
    chk("ovf_depth", depth_o, 8);
    for (int k = 1; k <= 8; k++) begin
      ret(1'b1);
      chk($sformatf("ret%0d_next", k), next_pc_o, 12'h00B - k);
    end
    idle();
    chk("drained_depth", depth_o, 0);
    chk("drained_no_unf", unf_o, 0);
    ret(1'b1);
    chk("ret9_next", next_pc_o, 12'h000);
    idle();
    chk("unf_set", unf_o, 1);
    chk("unf_depth", depth_o, 0);
    drive(1'b0, 1'b1, 1'b1, 3'd0, 12'h010, 1'b0, 8'h00, 12'h000);
    idle();
    chk("ovf_sticky", ovf_o, 1);
    chk("unf_sticky", unf_o, 1);

    // reset clears everything; cen=0 blocks a pop; reset during RET has no effect
    drive(1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 8'h00, 12'h000);
    idle();
    chk("rst2_ovf", ovf_o, 0);
    chk("rst2_unf", unf_o, 0);
    jsb(12'h010, 12'h100);
    jsb(12'h020, 12'h200);
    ret(1'b0);
    chk("cen0_we", pc_we_o, 0);
    chk("cen0_next", next_pc_o, 12'h031);
    idle();
    chk("cen0_depth", depth_o, 2);
    drive(1'b1, 1'b1, 1'b1, 3'd4, 12'h030, 1'b0, 8'h00, 12'h000);
    chk("rst_ret_we", pc_we_o, 0);
    idle();
    chk("rst_ret_depth", depth_o, 0);
    chk("rst_ret_ovf", ovf_o, 0);
    chk("rst_ret_unf", unf_o, 0);

    // reset with cen low still clears; then the stack behaves as empty
    jsb(12'h070, 12'h080);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 8'h00, 12'h000);
    idle();
    chk("rst_cen0_depth", depth_o, 0);
    jsb(12'h050, 12'h060);
    idle();
    chk("post_rst_depth", depth_o, 1);
    ret(1'b1);
    chk("post_rst_ret", next_pc_o, 12'h051);
    idle();
    chk("post_rst_unf", unf_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
